// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60) and small helpers used by the
// sync timing generator and the downstream pattern generator.
package vga_timing_pkg;

  localparam int POS_WIDTH      = 10;
  localparam int MAX_SYNC_DELAY = 7;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [POS_WIDTH-1:0] pos_t;
  // One extra bit so a bound equal to 2**POS_WIDTH is still representable.
  typedef logic [POS_WIDTH:0]   bound_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_pair_t;

  function automatic logic in_window(input bound_t pos, input bound_t lo, input bound_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic active_high);
    return active_high ? active : ~active;
  endfunction

endpackage

// File: rtl/vga_sync_timing_generator_sync_delay_line.sv
// Fixed-depth shift register used to align sync outputs with downstream
// registered video. DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int               WIDTH       = 2,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = i_clk ^ i_rst_n;
    assign o_data = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift every clock; reset flushes every stage to the idle level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_stage[i] <= RESET_VALUE;
        end
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_timing_generator.sv
// VGA raster timing: pixel/line counters, visible flag, frame strobe and
// polarity-configurable hsync/vsync through an alignment delay line.
module vga_sync_timing_generator #(
  parameter int H_VISIBLE        = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT          = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC           = vga_timing_pkg::H_SYNC,
  parameter int H_BACK           = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE        = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT          = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC           = vga_timing_pkg::V_SYNC,
  parameter int V_BACK           = vga_timing_pkg::V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int SYNC_DELAY       = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_enable,
  output logic [vga_timing_pkg::POS_WIDTH-1:0] o_hpos,
  output logic [vga_timing_pkg::POS_WIDTH-1:0] o_vpos,
  output logic                                o_visible,
  output logic                                o_frame_strobe,
  output logic                                o_hsync,
  output logic                                o_vsync
);

  import vga_timing_pkg::*;

  localparam int LINE_CLOCKS = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (LINE_CLOCKS > (1 << POS_WIDTH)) begin : g_bad_h_total
    $error("vga_sync_timing_generator: H total %0d exceeds %0d", LINE_CLOCKS, 1 << POS_WIDTH);
  end
  if (FRAME_LINES > (1 << POS_WIDTH)) begin : g_bad_v_total
    $error("vga_sync_timing_generator: V total %0d exceeds %0d", FRAME_LINES, 1 << POS_WIDTH);
  end
  if ((SYNC_DELAY < 0) || (SYNC_DELAY > MAX_SYNC_DELAY)) begin : g_bad_delay
    $error("vga_sync_timing_generator: SYNC_DELAY %0d out of range", SYNC_DELAY);
  end

  localparam pos_t   H_LAST     = pos_t'(LINE_CLOCKS - 1);
  localparam pos_t   V_LAST     = pos_t'(FRAME_LINES - 1);
  localparam bound_t H_VIS_END  = bound_t'(H_VISIBLE);
  localparam bound_t V_VIS_END  = bound_t'(V_VISIBLE);
  localparam bound_t HS_START   = bound_t'(H_VISIBLE + H_FRONT);
  localparam bound_t HS_END     = bound_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam bound_t VS_START   = bound_t'(V_VISIBLE + V_FRONT);
  localparam bound_t VS_END     = bound_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic   SYNC_HIGH  = (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic   SYNC_IDLE  = ~SYNC_HIGH;

  pos_t       r_hpos;
  pos_t       r_vpos;
  logic       r_visible;
  logic       r_frame_strobe;
  sync_pair_t r_sync_raw;

  pos_t       w_hpos_next;
  pos_t       w_vpos_next;
  logic       w_visible_next;
  logic       w_strobe_next;
  sync_pair_t w_sync_next;
  sync_pair_t w_sync_delayed;

  // Raster advance: hold when disabled, wrap the line then the frame.
  always_comb begin
    w_hpos_next = r_hpos;
    w_vpos_next = r_vpos;
    if (i_enable) begin
      if (r_hpos == H_LAST) begin
        w_hpos_next = pos_t'(0);
        if (r_vpos == V_LAST) begin
          w_vpos_next = pos_t'(0);
        end else begin
          w_vpos_next = r_vpos + pos_t'(1);
        end
      end else begin
        w_hpos_next = r_hpos + pos_t'(1);
        w_vpos_next = r_vpos;
      end
    end else begin
      w_hpos_next = r_hpos;
      w_vpos_next = r_vpos;
    end
  end

  // Decode from the next position so the flags land on the same clock as the counters.
  always_comb begin
    w_visible_next    = ({1'b0, w_hpos_next} < H_VIS_END) && ({1'b0, w_vpos_next} < V_VIS_END);
    w_strobe_next     = i_enable && (w_hpos_next == pos_t'(0)) && ({1'b0, w_vpos_next} == V_VIS_END);
    w_sync_next.hsync = sync_level(in_window({1'b0, w_hpos_next}, HS_START, HS_END), SYNC_HIGH);
    w_sync_next.vsync = sync_level(in_window({1'b0, w_vpos_next}, VS_START, VS_END), SYNC_HIGH);
  end

  // Counter and decode registers; reset parks on the last back-porch pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hpos         <= H_LAST;
      r_vpos         <= V_LAST;
      r_visible      <= 1'b0;
      r_frame_strobe <= 1'b0;
      r_sync_raw     <= '{hsync: SYNC_IDLE, vsync: SYNC_IDLE};
    end else begin
      r_hpos         <= w_hpos_next;
      r_vpos         <= w_vpos_next;
      r_visible      <= w_visible_next;
      r_frame_strobe <= w_strobe_next;
      r_sync_raw     <= w_sync_next;
    end
  end

  sync_delay_line #(
    .WIDTH       (2),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (r_sync_raw),
    .o_data  (w_sync_delayed)
  );

  assign o_hpos         = r_hpos;
  assign o_vpos         = r_vpos;
  assign o_visible      = r_visible;
  assign o_frame_strobe = r_frame_strobe;
  assign o_hsync        = w_sync_delayed.hsync;
  assign o_vsync        = w_sync_delayed.vsync;

endmodule

// File: tb/tb_vga_sync_timing_generator.sv
// Directed bench: default 640x480 timing, an active-high/3-stage variant and a
// tiny-raster variant (16x12, no delay) for frame-level behaviour.
module tb_vga_sync_timing_generator;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_enable;

  logic [9:0] d_hpos, d_vpos;
  logic       d_visible, d_strobe, d_hsync, d_vsync;
  logic [9:0] h_hpos, h_vpos;
  logic       h_visible, h_strobe, h_hsync, h_vsync;
  logic [9:0] s_hpos, s_vpos;
  logic       s_visible, s_strobe, s_hsync, s_vsync;

  int checks = 0;
  int errors = 0;

  vga_sync_timing_generator u_dut (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_enable (i_enable),
    .o_hpos (d_hpos), .o_vpos (d_vpos), .o_visible (d_visible),
    .o_frame_strobe (d_strobe), .o_hsync (d_hsync), .o_vsync (d_vsync)
  );

  vga_sync_timing_generator #(.SYNC_ACTIVE_HIGH(1), .SYNC_DELAY(3)) u_hi (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_enable (i_enable),
    .o_hpos (h_hpos), .o_vpos (h_vpos), .o_visible (h_visible),
    .o_frame_strobe (h_strobe), .o_hsync (h_hsync), .o_vsync (h_vsync)
  );

  // Small raster: H 8+2+3+3=16, V 6+2+2+2=12, hsync at hpos 10..12, vsync on lines 8..9.
  vga_sync_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE_HIGH(0), .SYNC_DELAY(0)
  ) u_small (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_enable (i_enable),
    .o_hpos (s_hpos), .o_vpos (s_vpos), .o_visible (s_visible),
    .o_frame_strobe (s_strobe), .o_hsync (s_hsync), .o_vsync (s_vsync)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (d_hpos !== 10'd799 || d_vpos !== 10'd524) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (799,524)", d_hpos, d_vpos);
    end
    checks++;
    if (d_visible !== 1'b0 || d_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got visible=%b strobe=%b expected 0 0", d_visible, d_strobe);
    end
    checks++;
    if (d_hsync !== 1'b1 || d_vsync !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync_low_pol: got h=%b v=%b expected 1 1", d_hsync, d_vsync);
    end
    checks++;
    if (h_hsync !== 1'b0 || h_vsync !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_high_pol: got h=%b v=%b expected 0 0", h_hsync, h_vsync);
    end
    checks++;
    if (s_hpos !== 10'd15 || s_vpos !== 10'd11) begin
      errors++;
      $display("FAIL reset_small_pos: got (%0d,%0d) expected (15,11)", s_hpos, s_vpos);
    end
  endtask

  // Release reset and walk line 0 of the default raster pixel by pixel.
  task automatic test_first_line();
    logic exp_hs_d, exp_hs_h;
    i_rst_n  = 1'b1;
    i_enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      exp_hs_d = !((i >= 657) && (i <= 752));
      exp_hs_h = (i >= 659) && (i <= 754);
      checks++;
      if (d_hpos !== 10'(i) || d_vpos !== 10'd0) begin
        errors++;
        $display("FAIL line0_pos: got (%0d,%0d) expected (%0d,0)", d_hpos, d_vpos, i);
      end
      checks++;
      if (d_visible !== (i < 640)) begin
        errors++;
        $display("FAIL line0_visible hpos=%0d: got %b expected %b", i, d_visible, (i < 640));
      end
      checks++;
      if (d_hsync !== exp_hs_d || d_vsync !== 1'b1 || d_strobe !== 1'b0) begin
        errors++;
        $display("FAIL line0_sync_d1 hpos=%0d: got h=%b v=%b s=%b expected h=%b v=1 s=0",
                 i, d_hsync, d_vsync, d_strobe, exp_hs_d);
      end
      checks++;
      if (h_hsync !== exp_hs_h || h_vsync !== 1'b0) begin
        errors++;
        $display("FAIL line0_sync_hi_d3 hpos=%0d: got h=%b v=%b expected h=%b v=0",
                 i, h_hsync, h_vsync, exp_hs_h);
      end
    end
    tick();
    checks++;
    if (d_hpos !== 10'd0 || d_vpos !== 10'd1 || d_hsync !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap: got (%0d,%0d) h=%b expected (0,1) h=1", d_hpos, d_vpos, d_hsync);
    end
  endtask

  task automatic test_enable_hold();
    repeat (3300) tick();
    checks++;
    if (d_hpos !== 10'd100 || d_vpos !== 10'd5 || d_visible !== 1'b1) begin
      errors++;
      $display("FAIL hold_entry: got (%0d,%0d) vis=%b expected (100,5) vis=1", d_hpos, d_vpos, d_visible);
    end
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (d_hpos !== 10'd100 || d_vpos !== 10'd5 || d_visible !== 1'b1 || d_strobe !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got (%0d,%0d) vis=%b s=%b expected (100,5) vis=1 s=0",
                 i, d_hpos, d_vpos, d_visible, d_strobe);
      end
    end
    i_enable = 1'b1;
    tick();
    checks++;
    if (d_hpos !== 10'd101 || d_vpos !== 10'd5) begin
      errors++;
      $display("FAIL hold_resume: got (%0d,%0d) expected (101,5)", d_hpos, d_vpos);
    end
  endtask

  // Assert reset between clock edges while hsync is active.
  task automatic test_async_reset();
    repeat (1399) tick();
    checks++;
    if (d_hpos !== 10'd700 || d_vpos !== 10'd6 || d_hsync !== 1'b0 || h_hsync !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got (%0d,%0d) hd=%b hh=%b expected (700,6) hd=0 hh=1",
               d_hpos, d_vpos, d_hsync, h_hsync);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (d_hpos !== 10'd799 || d_vpos !== 10'd524 || d_visible !== 1'b0 || d_strobe !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_pos: got (%0d,%0d) vis=%b s=%b expected (799,524) vis=0 s=0",
               d_hpos, d_vpos, d_visible, d_strobe);
    end
    checks++;
    if (d_hsync !== 1'b1 || d_vsync !== 1'b1 || h_hsync !== 1'b0 || h_vsync !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_sync: got d=%b%b h=%b%b expected d=11 h=00",
               d_hsync, d_vsync, h_hsync, h_vsync);
    end
    repeat (2) tick();
    checks++;
    if (d_hpos !== 10'd799 || h_hsync !== 1'b0 || s_hpos !== 10'd15 || s_vpos !== 10'd11) begin
      errors++;
      $display("FAIL reset_held: got d_hpos=%0d hh=%b small=(%0d,%0d) expected 799 0 (15,11)",
               d_hpos, h_hsync, s_hpos, s_vpos);
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (d_hpos !== 10'd0 || d_vpos !== 10'd0 || d_visible !== 1'b1 ||
        s_hpos !== 10'd0 || s_vpos !== 10'd0) begin
      errors++;
      $display("FAIL reset_release: got d=(%0d,%0d) vis=%b small=(%0d,%0d) expected (0,0) 1 (0,0)",
               d_hpos, d_vpos, d_visible, s_hpos, s_vpos);
    end
  endtask

  // Two full small-raster frames plus the wrap back to (0,0).
  task automatic test_small_frames();
    int h, v, strobes;
    logic exp_vis, exp_hs, exp_vs, exp_st;
    strobes = 0;
    for (int i = 0; i <= 384; i++) begin
      if (i > 0) tick();
      h = i % 16;
      v = (i / 16) % 12;
      exp_vis = (h < 8) && (v < 6);
      exp_hs  = !((h >= 10) && (h <= 12));
      exp_vs  = !((v == 8) || (v == 9));
      exp_st  = (h == 0) && (v == 6);
      checks++;
      if (s_hpos !== 10'(h) || s_vpos !== 10'(v)) begin
        errors++;
        $display("FAIL small_pos i=%0d: got (%0d,%0d) expected (%0d,%0d)", i, s_hpos, s_vpos, h, v);
      end
      checks++;
      if (s_visible !== exp_vis || s_strobe !== exp_st) begin
        errors++;
        $display("FAIL small_flags i=%0d: got vis=%b s=%b expected vis=%b s=%b",
                 i, s_visible, s_strobe, exp_vis, exp_st);
      end
      checks++;
      if (s_hsync !== exp_hs || s_vsync !== exp_vs) begin
        errors++;
        $display("FAIL small_sync i=%0d: got h=%b v=%b expected h=%b v=%b",
                 i, s_hsync, s_vsync, exp_hs, exp_vs);
      end
      if (s_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 2) begin
      errors++;
      $display("FAIL small_strobe_count: got %0d expected 2", strobes);
    end
  endtask

  // Hold the small raster right on the strobe position.
  task automatic test_strobe_hold();
    repeat (96) tick();
    checks++;
    if (s_hpos !== 10'd0 || s_vpos !== 10'd6 || s_strobe !== 1'b1) begin
      errors++;
      $display("FAIL strobe_arrive: got (%0d,%0d) s=%b expected (0,6) s=1", s_hpos, s_vpos, s_strobe);
    end
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_hpos !== 10'd0 || s_vpos !== 10'd6 || s_strobe !== 1'b0) begin
        errors++;
        $display("FAIL strobe_held%0d: got (%0d,%0d) s=%b expected (0,6) s=0", i, s_hpos, s_vpos, s_strobe);
      end
    end
    i_enable = 1'b1;
    tick();
    checks++;
    if (s_hpos !== 10'd1 || s_vpos !== 10'd6 || s_strobe !== 1'b0) begin
      errors++;
      $display("FAIL strobe_resume: got (%0d,%0d) s=%b expected (1,6) s=0", s_hpos, s_vpos, s_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_enable_hold();
    test_async_reset();
    test_small_frames();
    test_strobe_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
